// File: rtl/btn_conditioner_pkg.sv
// Shared types and default timing for the pushbutton conditioner.
// State encodings and 100 MHz timing defaults live here so every channel agrees on them.
package btn_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RPT  = 2'd2
    } rpt_state_t;

    localparam int DEF_N_BTN      = 4;
    localparam int DEF_DB_CYCLES  = 1_000_000;
    localparam int DEF_RPT_DELAY  = 50_000_000;
    localparam int DEF_RPT_PERIOD = 10_000_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_cond_ch.sv
// One pushbutton channel: 2-FF synchroniser, stable-time debouncer,
// press/release edge pulses and a hold-to-auto-repeat state machine.
module btn_cond_ch
    import btn_conditioner_pkg::*;
#(
    parameter int DB_CYCLES  = DEF_DB_CYCLES,
    parameter int RPT_DELAY  = DEF_RPT_DELAY,
    parameter int RPT_PERIOD = DEF_RPT_PERIOD
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    input  logic rpt_en,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_pulse
);

    localparam int DB_W  = $clog2(DB_CYCLES);
    localparam int TMR_W = $clog2(max_int(RPT_DELAY, RPT_PERIOD));

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DB_CYCLES - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(RPT_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(RPT_PERIOD - 1);

    logic             s1;
    logic             s2;
    logic [DB_W-1:0]  db_cnt;
    logic [TMR_W-1:0] tmr;
    rpt_state_t       state;

    logic db_done;
    logic rise;
    logic fall;

    // The level flips on the edge where the mismatch has lasted DB_CYCLES cycles.
    assign db_done = (s2 != btn_level) && (db_cnt == DB_LAST);
    assign rise    = db_done && s2;
    assign fall    = db_done && !s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            db_cnt      <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            s1          <= btn_raw;
            s2          <= s1;
            btn_press   <= rise;
            btn_release <= fall;
            if (s2 == btn_level) begin
                db_cnt <= '0;
            end else if (db_done) begin
                db_cnt    <= '0;
                btn_level <= s2;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // A debounced fall always wins: back to IDLE with no repeat pulse that cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            tmr       <= '0;
            btn_pulse <= 1'b0;
        end else begin
            btn_pulse <= rise;
            if (fall) begin
                state <= ST_IDLE;
                tmr   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rise) begin
                            state <= ST_WAIT;
                            tmr   <= '0;
                        end
                    end
                    ST_WAIT: begin
                        if (!rpt_en) begin
                            tmr <= '0;
                        end else if (tmr == DELAY_LAST) begin
                            btn_pulse <= 1'b1;
                            state     <= ST_RPT;
                            tmr       <= '0;
                        end else begin
                            tmr <= tmr + 1'b1;
                        end
                    end
                    ST_RPT: begin
                        if (!rpt_en) begin
                            state <= ST_WAIT;
                            tmr   <= '0;
                        end else if (tmr == PERIOD_LAST) begin
                            btn_pulse <= 1'b1;
                            tmr       <= '0;
                        end else begin
                            tmr <= tmr + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        tmr   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Pushbutton front-end: N_BTN identical, fully independent conditioning channels
// feeding the LED counter and PWM brightness logic.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int N_BTN      = DEF_N_BTN,
    parameter int DB_CYCLES  = DEF_DB_CYCLES,
    parameter int RPT_DELAY  = DEF_RPT_DELAY,
    parameter int RPT_PERIOD = DEF_RPT_PERIOD
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] rpt_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_pulse
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_cond_ch #(
            .DB_CYCLES  (DB_CYCLES),
            .RPT_DELAY  (RPT_DELAY),
            .RPT_PERIOD (RPT_PERIOD)
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .btn_raw     (btn_raw[i]),
            .rpt_en      (rpt_en[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_pulse   (btn_pulse[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: a window-based reference model predicts
// every cycle's outputs into a queue; an independent monitor pops and compares.
module tb_btn_conditioner;

    localparam int N_BTN      = 4;
    localparam int DB_CYCLES  = 4;
    localparam int RPT_DELAY  = 20;
    localparam int RPT_PERIOD = 8;
    localparam int WIN        = DB_CYCLES + 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [N_BTN-1:0] btn_raw = '0;
    logic [N_BTN-1:0] rpt_en = '0;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_pulse;

    int checks = 0;
    int errors = 0;

    logic [4*N_BTN-1:0] exp_q[$];

    // Reference state: recent raw samples per channel plus a hold/repeat summary.
    logic samp [N_BTN][WIN];
    logic m_level    [N_BTN];
    logic m_held     [N_BTN];
    logic m_periodic [N_BTN];
    int   m_cnt      [N_BTN];

    btn_conditioner #(
        .N_BTN      (N_BTN),
        .DB_CYCLES  (DB_CYCLES),
        .RPT_DELAY  (RPT_DELAY),
        .RPT_PERIOD (RPT_PERIOD)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_raw     (btn_raw),
        .rpt_en      (rpt_en),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_pulse   (btn_pulse)
    );

    always #5 clk = ~clk;

    // Level changes once the raw samples taken 2..DB_CYCLES+1 edges ago all disagree with it;
    // repeats fire after RPT_DELAY enabled held cycles, then every RPT_PERIOD.
    task automatic model_step();
        logic [N_BTN-1:0] lv, pr, rl, pu;
        logic settled, rep;
        lv = '0; pr = '0; rl = '0; pu = '0;
        for (int c = 0; c < N_BTN; c++) begin
            if (!reset_n) begin
                for (int j = 0; j < WIN; j++) samp[c][j] = 1'b0;
                m_level[c]    = 1'b0;
                m_held[c]     = 1'b0;
                m_periodic[c] = 1'b0;
                m_cnt[c]      = 0;
            end else begin
                for (int j = WIN - 1; j > 0; j--) samp[c][j] = samp[c][j-1];
                samp[c][0] = btn_raw[c];
                settled = 1'b1;
                for (int j = 2; j < WIN; j++) if (samp[c][j] == m_level[c]) settled = 1'b0;
                rep = 1'b0;
                if (settled && !m_level[c]) begin
                    pr[c] = 1'b1;
                    m_level[c] = 1'b1;
                    m_held[c] = 1'b1;
                    m_periodic[c] = 1'b0;
                    m_cnt[c] = 0;
                end else if (settled && m_level[c]) begin
                    rl[c] = 1'b1;
                    m_level[c] = 1'b0;
                    m_held[c] = 1'b0;
                end else if (m_held[c]) begin
                    if (!rpt_en[c]) begin
                        m_cnt[c] = 0;
                        m_periodic[c] = 1'b0;
                    end else begin
                        m_cnt[c]++;
                        if (m_cnt[c] == (m_periodic[c] ? RPT_PERIOD : RPT_DELAY)) begin
                            rep = 1'b1;
                            m_cnt[c] = 0;
                            m_periodic[c] = 1'b1;
                        end
                    end
                end
                lv[c] = m_level[c];
                pu[c] = pr[c] | rep;
            end
        end
        exp_q.push_back({lv, pr, rl, pu});
    endtask

    task automatic check_output(input logic [4*N_BTN-1:0] exp);
        logic [N_BTN-1:0] e_lv, e_pr, e_rl, e_pu;
        {e_lv, e_pr, e_rl, e_pu} = exp;
        checks += 4;
        if (btn_level !== e_lv) begin
            errors++;
            $display("[TB] FAIL level t=%0t got=%b exp=%b", $time, btn_level, e_lv);
        end
        if (btn_press !== e_pr) begin
            errors++;
            $display("[TB] FAIL press t=%0t got=%b exp=%b", $time, btn_press, e_pr);
        end
        if (btn_release !== e_rl) begin
            errors++;
            $display("[TB] FAIL release t=%0t got=%b exp=%b", $time, btn_release, e_rl);
        end
        if (btn_pulse !== e_pu) begin
            errors++;
            $display("[TB] FAIL pulse t=%0t got=%b exp=%b", $time, btn_pulse, e_pu);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        logic [4*N_BTN-1:0] e;
        @(negedge clk);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_output(e);
        end
    end

    task automatic apply_stimulus(input logic [N_BTN-1:0] raw, input logic [N_BTN-1:0] en,
                                  input int hold);
        @(posedge clk);
        #1;
        btn_raw = raw;
        rpt_en  = en;
        repeat (hold) @(posedge clk);
    endtask

    task automatic set_reset(input logic value);
        @(negedge clk);
        #1;
        reset_n = value;
    endtask

    initial begin
        logic [N_BTN-1:0] raw, en;
        btn_raw = 4'hF;
        rpt_en  = '0;
        reset_n = 1'b0;
        repeat (4) @(posedge clk);
        set_reset(1'b1);
        apply_stimulus(4'hF, 4'h0, 12);
        apply_stimulus(4'h0, 4'h0, 12);

        $display("[TB] bounce on channel 0");
        apply_stimulus(4'h1, 4'h0, 2);
        apply_stimulus(4'h0, 4'h0, 2);
        apply_stimulus(4'h1, 4'h0, 14);
        apply_stimulus(4'h0, 4'h0, 12);

        $display("[TB] auto-repeat on channel 1, long hold then mid-repeat release");
        apply_stimulus(4'h2, 4'h2, 70);
        apply_stimulus(4'h0, 4'h2, 12);
        apply_stimulus(4'h2, 4'h2, 36);
        apply_stimulus(4'h0, 4'h2, 12);

        $display("[TB] rpt_en gating on channel 2");
        apply_stimulus(4'h4, 4'h0, 45);
        apply_stimulus(4'h4, 4'h4, 35);
        apply_stimulus(4'h4, 4'h0, 5);
        apply_stimulus(4'h4, 4'h4, 30);
        apply_stimulus(4'h0, 4'h0, 12);

        $display("[TB] simultaneous press on channels 0 and 3 during channel 1 repeat");
        apply_stimulus(4'h2, 4'h2, 27);
        apply_stimulus(4'hB, 4'h2, 40);
        apply_stimulus(4'h0, 4'h0, 12);

        $display("[TB] reset while buttons are held");
        apply_stimulus(4'h5, 4'h5, 30);
        set_reset(1'b0);
        repeat (3) @(posedge clk);
        set_reset(1'b1);
        apply_stimulus(4'h5, 4'h5, 30);
        apply_stimulus(4'h0, 4'h0, 12);

        $display("[TB] randomized hold and bounce patterns");
        raw = '0;
        en  = '0;
        for (int i = 0; i < 80; i++) begin
            raw = raw ^ N_BTN'($urandom_range(0, 15) & $urandom_range(0, 15));
            en  = N_BTN'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0)
                apply_stimulus(raw, en, $urandom_range(1, 4));
            else
                apply_stimulus(raw, en, $urandom_range(5, 45));
            if (i == 40) begin
                set_reset(1'b0);
                repeat (2) @(posedge clk);
                set_reset(1'b1);
            end
        end
        apply_stimulus(4'h0, 4'h0, 15);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
